multu_sequencer: RTL and testbench
==================================

MULTU_SEQUENCER -- requirements
Module: multu_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, setting the operand width; the product is 2*WIDTH bits wide.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req_valid, input, 1 bit: a request is present.
REQ-005 The block SHALL have port req_op, input, 2 bits: 00 MULTU, 01 MFHI, 10 MFLO, 11 reserved.
REQ-006 The block SHALL have ports dataA and dataB, input, WIDTH bits each: multiplicand and multiplier.
REQ-007 The block SHALL have port req_ready, output, 1 bit: a request is accepted when req_valid and req_ready are both high on a clk edge.
REQ-008 The block SHALL have port rsp_valid, output, 1 bit: a one-cycle pulse qualifying rsp_data.
REQ-009 The block SHALL have port rsp_data, output, WIDTH bits: the MFHI/MFLO result.
REQ-010 The block SHALL have ports HiOut and LoOut, output, WIDTH bits each: the committed Hi and Lo registers.
REQ-011 The block SHALL have port busy, output, 1 bit: high while a multiply is in progress.

Function
REQ-012 The block SHALL implement three states, IDLE, MUL and COMMIT, and SHALL drive req_ready high only in IDLE.
REQ-013 In IDLE, an accepted MULTU SHALL perform all of the following, then go to MUL:
- latch mcand = zero-extended dataA (2*WIDTH bits);
- latch mplier = dataB;
- clear prod to 0 and cnt to 0.
REQ-014 Each cycle in MUL SHALL perform all of the following:
- if mplier[0] is 1, add mcand to prod;
- shift mcand left by 1;
- shift mplier right by 1 (logical);
- increment cnt.
REQ-015 The block SHALL leave MUL for COMMIT after the step in which cnt reaches WIDTH-1, i.e. after WIDTH MUL cycles.
REQ-016 In COMMIT, the block SHALL load HiOut with prod[2*WIDTH-1:WIDTH] and LoOut with prod[WIDTH-1:0], then return to IDLE; the product is unsigned and no overflow is possible.
REQ-017 The block SHALL hold busy high in MUL and COMMIT; HiOut/LoOut SHALL become visible WIDTH+2 cycles after the accept edge.
REQ-018 An accepted MFHI or MFLO SHALL produce rsp_valid=1 on the next cycle, with rsp_data equal to HiOut or LoOut, and the state SHALL stay IDLE.
REQ-019 The block SHALL clear rsp_valid to 0 in every cycle that does not carry a response.
REQ-020 The block SHALL accept a reserved op (11) and ignore it: no state change and no response.
REQ-021 While busy, req_ready SHALL be 0, so MFHI/MFLO stall until the product has committed; a requester SHALL hold req_valid and req_op stable until accepted.
REQ-022 The block SHALL accept a new request in the cycle immediately after COMMIT (back-to-back operation), and MFHI/MFLO accepted then SHALL return the new values.
REQ-023 The block SHALL ignore dataA and dataB changes after the accept edge.

Reset
REQ-024 Asserting reset (low) SHALL immediately force all of the following, including mid-multiply, in which case the partial product is discarded:
- state = IDLE;
- HiOut = 0 and LoOut = 0;
- prod, mcand, mplier and cnt = 0;
- rsp_valid = 0, rsp_data = 0 and busy = 0.
REQ-025 req_ready SHALL be 1 while reset is low; requests SHALL NOT be accepted until the first clk edge after reset deasserts.

Configuration
REQ-026 When macro MULTU_SEQ_EARLY_EXIT_EN is defined, MUL SHALL also exit to COMMIT after any step that leaves mplier == 0; MUL length is then max(1, index of dataB's highest set bit + 1) cycles, and results SHALL be identical to the full-length multiply.
REQ-027 When MULTU_SEQ_EARLY_EXIT_EN is undefined, every MULTU SHALL take exactly WIDTH MUL cycles.

Structure
REQ-028 Package multu_seq_pkg SHALL hold the req_op encodings (OP_MULTU, OP_MFHI, OP_MFLO, OP_RSVD) and the state enum (IDLE, MUL, COMMIT).
REQ-029 The shift-add datapath (prod, mcand, mplier, cnt) SHALL be a separate sub-module, multu_shift_add_dp, controlled by the state machine in multu_sequencer.

Verification
REQ-030 The bench SHALL cover MULTU 3 x 5, then MFLO -> LoOut=15, HiOut=0, rsp_data=15 one cycle after MFLO accept.
REQ-031 The bench SHALL cover MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HiOut=0xFFFFFFFE, LoOut=0x00000001, committed 34 cycles after accept (early exit off).
REQ-032 The bench SHALL cover MFHI issued 1 cycle after a MULTU accept -> req_ready held low for the busy period; the MFHI is accepted the cycle after COMMIT and returns the new Hi.
REQ-033 The bench SHALL cover reset pulsed low at MUL cycle 10 of 0x1234 x 0x5678 -> HiOut=LoOut=0, busy=0, and the next MULTU 2 x 2 gives LoOut=4.
REQ-034 The bench SHALL cover MULTU 7 x 1 with MULTU_SEQ_EARLY_EXIT_EN defined -> 1 MUL cycle, LoOut=7 committed 3 cycles after accept; the same stimulus without the macro commits after 34 cycles.
REQ-035 The bench SHALL cover req_op=11 with req_valid high for 3 cycles -> no rsp_valid, busy stays 0, and HiOut/LoOut are unchanged.

Source files
------------

// File: rtl/multu_seq_pkg.sv
// =============================================================================
// Module      : multu_seq_pkg
// Description : Request opcode encodings and FSM state encoding for the
//               sequential unsigned multiplier.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package multu_seq_pkg;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MFHI  = 2'b01;
    localparam logic [1:0] OP_MFLO  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MUL    = 2'd1,
        COMMIT = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/multu_sequencer_if.sv
// =============================================================================
// Module      : multu_sequencer_if
// Description : Request/response and result bus of the sequential multiplier.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

interface multu_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic [1:0]       req_op;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic             req_ready;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_data;
    logic [WIDTH-1:0] HiOut;
    logic [WIDTH-1:0] LoOut;
    logic             busy;

    modport master (
        output req_valid, req_op, dataA, dataB,
        input  req_ready, rsp_valid, rsp_data, HiOut, LoOut, busy
    );

    modport slave (
        input  req_valid, req_op, dataA, dataB,
        output req_ready, rsp_valid, rsp_data, HiOut, LoOut, busy
    );
endinterface

`default_nettype wire

// File: rtl/multu_shift_add_dp.sv
// =============================================================================
// Module      : multu_shift_add_dp
// Description : Shift-add datapath, one multiplier bit per step.
//               MULTU_SEQ_EARLY_EXIT_EN: o_last also fires once the remaining
//               multiplier bits are all zero.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module multu_shift_add_dp #(
    parameter int WIDTH = 32
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               i_load,
    input  wire logic               i_step,
    input  wire logic [WIDTH-1:0]   i_a,
    input  wire logic [WIDTH-1:0]   i_b,
    output logic      [2*WIDTH-1:0] o_prod,
    output logic                    o_last
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] c_LAST_CNT = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] r_prod;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prod   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (i_load) begin
            r_prod   <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, i_a};
            r_mplier <= i_b;
            r_cnt    <= '0;
        end else if (i_step) begin
            if (r_mplier[0]) begin
                r_prod <= r_prod + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    // Flags the step currently being taken as the final one.
`ifdef MULTU_SEQ_EARLY_EXIT_EN
    assign o_last = (r_cnt == c_LAST_CNT) || (r_mplier[WIDTH-1:1] == '0);
`else
    assign o_last = (r_cnt == c_LAST_CNT);
`endif

    assign o_prod = r_prod;

endmodule

`default_nettype wire

// File: rtl/multu_sequencer.sv
// =============================================================================
// Module      : multu_sequencer
// Description : Sequential unsigned multiplier with Hi/Lo result registers and
//               MFHI/MFLO read requests. Optional MULTU_SEQ_EARLY_EXIT_EN.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module multu_sequencer
    import multu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic         clk,
    input  wire logic         reset,
    multu_sequencer_if.slave  bus
);
    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_MUL    = MUL;
    localparam logic [1:0] S_COMMIT = COMMIT;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_rsp_valid;
    logic [WIDTH-1:0]   r_rsp_data;

    logic               w_accept;
    logic               w_load;
    logic               w_last;
    logic [2*WIDTH-1:0] w_prod;

    assign w_accept = bus.req_valid && (r_state == S_IDLE);
    assign w_load   = w_accept && (bus.req_op == OP_MULTU);

    multu_shift_add_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_load),
        .i_step (r_state == S_MUL),
        .i_a    (bus.dataA),
        .i_b    (bus.dataB),
        .o_prod (w_prod),
        .o_last (w_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_load) begin
                        r_state <= S_MUL;
                    end
                end
                S_MUL: begin
                    if (w_last) begin
                        r_state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    r_hi    <= w_prod[2*WIDTH-1:WIDTH];
                    r_lo    <= w_prod[WIDTH-1:0];
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // rsp_data keeps its last value; only rsp_valid is a pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (w_accept && (bus.req_op == OP_MFHI)) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= r_hi;
            end else if (w_accept && (bus.req_op == OP_MFLO)) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= r_lo;
            end
        end
    end

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.HiOut     = r_hi;
    assign bus.LoOut     = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_multu_sequencer.sv
// =============================================================================
// Module      : tb_multu_sequencer
// Description : Directed self-checking bench for multu_sequencer with a
//               transaction-level model; honours MULTU_SEQ_EARLY_EXIT_EN.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_multu_sequencer;
    localparam int W = 32;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    multu_sequencer_if #(.WIDTH(W)) bus ();

    multu_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Number of MUL cycles a multiply must take.
    function automatic int mul_len(input logic [W-1:0] b);
        int n;
        n = W;
`ifdef MULTU_SEQ_EARLY_EXIT_EN
        n = 1;
        for (int i = 0; i < W; i++) begin
            if (b[i]) n = i + 1;
        end
`endif
        return n;
    endfunction

    // Transaction model: countdown to commit, then product visible.
    int           m_left = 0;
    logic [63:0]  m_pend = '0;
    logic [W-1:0] m_hi   = '0;
    logic [W-1:0] m_lo   = '0;
    logic [W-1:0] m_rsp  = '0;
    bit           m_rv   = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_left <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_rv   <= 1'b0;
        end else begin
            m_rv <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_hi <= m_pend[63:32];
                    m_lo <= m_pend[31:0];
                end
            end else if (bus.req_valid) begin
                case (bus.req_op)
                    2'b00: begin
                        m_pend <= 64'(bus.dataA) * 64'(bus.dataB);
                        m_left <= mul_len(bus.dataB) + 1;
                    end
                    2'b01: begin m_rv <= 1'b1; m_rsp <= m_hi; end
                    2'b10: begin m_rv <= 1'b1; m_rsp <= m_lo; end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        chk("req_ready", 64'(bus.req_ready), 64'(m_left == 0));
        chk("busy",      64'(bus.busy),      64'(m_left != 0));
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_rv));
        chk("HiOut",     64'(bus.HiOut),     64'(m_hi));
        chk("LoOut",     64'(bus.LoOut),     64'(m_lo));
        if (m_rv) chk("rsp_data", 64'(bus.rsp_data), 64'(m_rsp));
    end

    task automatic wait_ready(input string nm);
        int g;
        g = 0;
        while (!bus.req_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) chk({nm, "_ready_timeout"}, 64'(0), 64'(1));
    endtask

    task automatic do_multu(input logic [W-1:0] a, input logic [W-1:0] b,
                            input int exp_lat, input string nm);
        int n;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b00;
        bus.dataA     = a;
        bus.dataB     = b;
        wait_ready(nm);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.dataA     = $urandom;
        bus.dataB     = $urandom;
        n = 1;
        while (bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, 64'(n), 64'(exp_lat));
    endtask

    task automatic do_mfx(input logic [1:0] op, input logic [W-1:0] exp, input string nm);
        if (!bus.req_ready) @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        wait_ready(nm);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk({nm, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(1));
        chk({nm, "_rsp_data"},  64'(bus.rsp_data),  64'(exp));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat_3x5, lat_7x1, lat_2x2, rdy_low, cnt;
`ifdef MULTU_SEQ_EARLY_EXIT_EN
        lat_3x5 = 5; lat_7x1 = 3; lat_2x2 = 4; rdy_low = 4;
`else
        lat_3x5 = 34; lat_7x1 = 34; lat_2x2 = 34; rdy_low = 33;
`endif
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.dataA     = '0;
        bus.dataB     = '0;
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(bus.req_ready), 64'(1));
        chk("rst_busy",  64'(bus.busy),      64'(0));
        chk("rst_hi",    64'(bus.HiOut),     64'(0));
        chk("rst_rsp",   64'(bus.rsp_data),  64'(0));
        #1 reset = 1'b1;

        // 3 x 5 then MFLO
        do_multu(32'd3, 32'd5, lat_3x5, "m3x5");
        chk("m3x5_hi", 64'(bus.HiOut), 64'(0));
        chk("m3x5_lo", 64'(bus.LoOut), 64'(15));
        do_mfx(2'b10, 32'd15, "mflo15");

        // all-ones squared
        do_multu(32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "mff");
        chk("mff_hi", 64'(bus.HiOut), 64'hFFFF_FFFE);
        chk("mff_lo", 64'(bus.LoOut), 64'h0000_0001);
        do_mfx(2'b01, 32'hFFFF_FFFE, "mfhi_ff");

        // MFHI issued one cycle after the MULTU accept stalls until commit
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b00;
        bus.dataA     = 32'h8000_0000;
        bus.dataB     = 32'd6;
        @(posedge clk);
        @(negedge clk);
        bus.req_op    = 2'b01;
        bus.dataA     = $urandom;
        bus.dataB     = $urandom;
        cnt = 0;
        while (!bus.req_ready && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        chk("stall_cycles", 64'(cnt), 64'(rdy_low));
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("stall_rsp_valid", 64'(bus.rsp_valid), 64'(1));
        chk("stall_rsp_data",  64'(bus.rsp_data),  64'(3));

        // reset pulsed in the middle of a multiply
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b00;
        bus.dataA     = 32'h1234;
        bus.dataB     = 32'h5678;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (9) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_hi",    64'(bus.HiOut),     64'(0));
        chk("mid_rst_lo",    64'(bus.LoOut),     64'(0));
        chk("mid_rst_busy",  64'(bus.busy),      64'(0));
        chk("mid_rst_ready", 64'(bus.req_ready), 64'(1));
        @(negedge clk);
        #1 reset = 1'b1;
        do_multu(32'd2, 32'd2, lat_2x2, "m2x2");
        do_mfx(2'b10, 32'd4, "mflo4");

        // short multiplier
        do_multu(32'd7, 32'd1, lat_7x1, "m7x1");
        chk("m7x1_lo", 64'(bus.LoOut), 64'(7));

        // reserved op held for three cycles
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b11;
        repeat (3) begin
            @(negedge clk);
            chk("rsvd_rsp_valid", 64'(bus.rsp_valid), 64'(0));
            chk("rsvd_busy",      64'(bus.busy),      64'(0));
        end
        bus.req_valid = 1'b0;
        chk("rsvd_hi", 64'(bus.HiOut), 64'(0));
        chk("rsvd_lo", 64'(bus.LoOut), 64'(7));

        // back-to-back: MFLO accepted the cycle after commit
        do_multu(32'd10, 32'd10, 34 - ((W - mul_len(32'd10))), "m10x10");
        do_mfx(2'b10, 32'd100, "mflo100");

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
